// File: rtl/pc_pkg.sv
// Shared definitions for the program counter unit: next-PC operation codes.
package pc_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_INC    = 3'd0;
  localparam logic [OP_W-1:0] OP_JUMP   = 3'd1;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
  localparam logic [OP_W-1:0] OP_RET    = 3'd4;
  localparam logic [OP_W-1:0] OP_NOP    = 3'd5;
endpackage

// File: rtl/pc_return_stack.sv
// Bounded LIFO of return addresses; push ignored when full, pop ignored when empty.
module pc_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int SP_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [SP_W-1:0]  sp,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SP_W-1:0]  r_sp;

  assign sp    = r_sp;
  assign full  = (r_sp == SP_W'(DEPTH));
  assign empty = (r_sp == '0);

  always_ff @(posedge clk) begin
    if (!reset)
      r_sp <= '0;
    else if (push && !full)
      r_sp <= r_sp + 1'b1;
    else if (pop && !empty)
      r_sp <= r_sp - 1'b1;
  end

  // Entry storage is left unreset; only sp defines which entries are live.
  always_ff @(posedge clk) begin
    if (reset && push && !full)
      for (int i = 0; i < DEPTH; i++)
        if (SP_W'(i) == r_sp) r_mem[i] <= din;
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (SP_W'(i + 1) == r_sp) dout = r_mem[i];
  end
endmodule

// File: rtl/program_counter_unit.sv
// Program counter with step/jump/relative branch, call/return stack and sticky
// stack error flags. All outputs are registered or derived from registers.
module program_counter_unit
  import pc_pkg::*;
#(
  parameter int                 WIDTH        = 8,
  parameter int unsigned        STEP         = 1,
  parameter int                 OFS_W        = 8,
  parameter int                 DEPTH        = 4,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       stall,
  input  logic [OP_W-1:0]            op,
  input  logic [WIDTH-1:0]           target,
  input  logic [OFS_W-1:0]           offset,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       err_ovf,
  output logic                       err_unf
);
  logic [WIDTH-1:0] r_pc;
  logic             r_err_ovf;
  logic             r_err_unf;

  logic             w_active;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_ofs_ext;
  logic [WIDTH-1:0] w_pc_nxt;

  assign w_active = reset && !stall && en;
  assign w_push   = w_active && (op == OP_CALL);
  assign w_pop    = w_active && (op == OP_RET);
  assign w_seq    = r_pc + WIDTH'(STEP);

  generate
    if (WIDTH > OFS_W) begin : g_sext
      assign w_ofs_ext = {{(WIDTH-OFS_W){offset[OFS_W-1]}}, offset};
    end else begin : g_noext
      assign w_ofs_ext = offset;
    end
  endgenerate

  pc_return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_seq),
    .dout  (w_top),
    .sp    (sp),
    .full  (w_full),
    .empty (w_empty)
  );

  // A CALL on a full stack or a RET on an empty one leaves pc untouched.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_active) begin
      case (op)
        OP_INC:    w_pc_nxt = w_seq;
        OP_JUMP:   w_pc_nxt = target;
        OP_BRANCH: w_pc_nxt = r_pc + w_ofs_ext;
        OP_CALL:   if (!w_full)  w_pc_nxt = target;
        OP_RET:    if (!w_empty) w_pc_nxt = w_top;
        default:   w_pc_nxt = r_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= RESET_VECTOR;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_push && w_full)  r_err_ovf <= 1'b1;
      if (w_pop  && w_empty) r_err_unf <= 1'b1;
    end
  end

  assign pc          = r_pc;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign err_ovf     = r_err_ovf;
  assign err_unf     = r_err_unf;
endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_program_counter_unit;
  import pc_pkg::*;

  logic       clk = 1'b0;
  logic       reset, en, stall;
  logic [2:0] op;
  logic [7:0] target, offset;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stack_full, stack_empty, err_ovf, err_unf;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    int         id;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_id   = 0;

  always #5 clk = ~clk;

  program_counter_unit #(
    .WIDTH(8), .STEP(1), .OFS_W(8), .DEPTH(4), .RESET_VECTOR(8'h10)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .stall(stall), .op(op),
    .target(target), .offset(offset), .pc(pc), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // Drive one cycle of inputs, then queue the state expected after that edge.
  task automatic vec(input logic r, input logic s, input logic e, input logic [2:0] o,
                     input logic [7:0] t, input logic [7:0] f,
                     input logic [7:0] epc, input logic [2:0] esp,
                     input logic eovf, input logic eunf);
    exp_t x;
    reset = r; stall = s; en = e; op = o; target = t; offset = f;
    @(posedge clk);
    x.pc = epc; x.sp = esp; x.full = (esp == 3'd4); x.empty = (esp == 3'd0);
    x.ovf = eovf; x.unf = eunf; x.id = n_id;
    n_id++;
    q.push_back(x);
    #1;
  endtask

  task automatic act(input logic [2:0] o, input logic [7:0] t, input logic [7:0] f,
                     input logic [7:0] epc, input logic [2:0] esp,
                     input logic eovf, input logic eunf);
    vec(1'b1, 1'b0, 1'b1, o, t, f, epc, esp, eovf, eunf);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_vec++;
      if (pc !== x.pc || sp !== x.sp || stack_full !== x.full || stack_empty !== x.empty ||
          err_ovf !== x.ovf || err_unf !== x.unf) begin
        n_fail++;
        $display("FAIL vec%0d: got pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
                 x.id, pc, sp, stack_full, stack_empty, err_ovf, err_unf,
                 x.pc, x.sp, x.full, x.empty, x.ovf, x.unf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; en = 1'b1; op = OP_INC; target = '0; offset = '0;
    // reset state, then sequential advance
    vec(1'b0, 1'b0, 1'b1, OP_INC, 8'h00, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0);
    vec(1'b0, 1'b0, 1'b1, OP_INC, 8'h00, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++)
      act(OP_INC, 8'h00, 8'h00, 8'(8'h10 + i), 3'd0, 1'b0, 1'b0);
    // wrap-around
    act(OP_JUMP, 8'hFE, 8'h00, 8'hFE, 3'd0, 1'b0, 1'b0);
    act(OP_INC,  8'h00, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0);
    act(OP_INC,  8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    act(OP_INC,  8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0);
    // relative branches
    act(OP_JUMP,   8'h20, 8'h00, 8'h20, 3'd0, 1'b0, 1'b0);
    act(OP_BRANCH, 8'h00, 8'hF0, 8'h10, 3'd0, 1'b0, 1'b0);
    act(OP_BRANCH, 8'h00, 8'h05, 8'h15, 3'd0, 1'b0, 1'b0);
    // stall overrides en, en=0 holds, stalled CALL must not push
    for (int i = 0; i < 3; i++)
      vec(1'b1, 1'b1, 1'b1, OP_INC, 8'h00, 8'h00, 8'h15, 3'd0, 1'b0, 1'b0);
    vec(1'b1, 1'b1, 1'b1, OP_CALL, 8'h99, 8'h00, 8'h15, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      vec(1'b1, 1'b0, 1'b0, OP_INC, 8'h00, 8'h00, 8'h15, 3'd0, 1'b0, 1'b0);
    act(OP_INC, 8'h00, 8'h00, 8'h16, 3'd0, 1'b0, 1'b0);
    // nested calls to full, then overflow
    act(OP_JUMP, 8'h30, 8'h00, 8'h30, 3'd0, 1'b0, 1'b0);
    act(OP_CALL, 8'h40, 8'h00, 8'h40, 3'd1, 1'b0, 1'b0);
    act(OP_CALL, 8'h50, 8'h00, 8'h50, 3'd2, 1'b0, 1'b0);
    act(OP_CALL, 8'h60, 8'h00, 8'h60, 3'd3, 1'b0, 1'b0);
    act(OP_CALL, 8'h70, 8'h00, 8'h70, 3'd4, 1'b0, 1'b0);
    act(OP_CALL, 8'h80, 8'h00, 8'h70, 3'd4, 1'b1, 1'b0);
    // unwind, then underflow
    act(OP_RET, 8'h00, 8'h00, 8'h61, 3'd3, 1'b1, 1'b0);
    act(OP_RET, 8'h00, 8'h00, 8'h51, 3'd2, 1'b1, 1'b0);
    act(OP_RET, 8'h00, 8'h00, 8'h41, 3'd1, 1'b1, 1'b0);
    act(OP_RET, 8'h00, 8'h00, 8'h31, 3'd0, 1'b1, 1'b0);
    act(OP_RET, 8'h00, 8'h00, 8'h31, 3'd0, 1'b1, 1'b1);
    // NOP and reserved codes hold; flags persist
    act(OP_NOP, 8'hAA, 8'h07, 8'h31, 3'd0, 1'b1, 1'b1);
    act(3'd6,   8'hAA, 8'h07, 8'h31, 3'd0, 1'b1, 1'b1);
    act(3'd7,   8'hAA, 8'h07, 8'h31, 3'd0, 1'b1, 1'b1);
    act(OP_INC, 8'h00, 8'h00, 8'h32, 3'd0, 1'b1, 1'b1);
    // reset in the middle of a CALL at sp=2
    act(OP_JUMP, 8'h30, 8'h00, 8'h30, 3'd0, 1'b1, 1'b1);
    act(OP_CALL, 8'h40, 8'h00, 8'h40, 3'd1, 1'b1, 1'b1);
    act(OP_CALL, 8'h50, 8'h00, 8'h50, 3'd2, 1'b1, 1'b1);
    vec(1'b0, 1'b0, 1'b1, OP_CALL, 8'h60, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0);
    act(OP_INC, 8'h00, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0);
    // CALL then RET returns to call site + STEP; large negative branch
    act(OP_CALL,   8'hA0, 8'h00, 8'hA0, 3'd1, 1'b0, 1'b0);
    act(OP_RET,    8'h00, 8'h00, 8'h12, 3'd0, 1'b0, 1'b0);
    act(OP_BRANCH, 8'h00, 8'h80, 8'h92, 3'd0, 1'b0, 1'b0);
    act(OP_BRANCH, 8'h00, 8'h7F, 8'h11, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never compared, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
